audio_gain_ramp: RTL and testbench

Stereo gain stage that sits between the I2S2 codec interface's ADC outputs and its DAC inputs. Each frame strobe it takes the left and right 24-bit ADC samples, applies a gain that ramps smoothly toward a target, and saturates the result. The block holds the results on its outputs, which feed the DAC inputs. It also reports per-channel peak magnitude and sticky clip flags for status LEDs and the seven-segment display.

---
 rtl/audio_gain_ramp.sv | 198 +++++++++++++++++++
 tb/tb_audio_gain_ramp.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_gain_ramp.sv
// Stereo gain stage: ramps the applied gain one step toward the (mute-aware) target
// every RAMP_DIV frame strobes, scales and saturates each sample, and tracks peak/clip status.
module audio_gain_ramp #(
    parameter int RAMP_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe,
    input  logic [23:0] in_l,
    input  logic [23:0] in_r,
    input  logic [7:0]  gain_target,
    input  logic        mute,
    input  logic        peak_clr,
    output logic [23:0] out_l,
    output logic [23:0] out_r,
    output logic        out_valid,
    output logic [7:0]  cur_gain,
    output logic [22:0] peak_l,
    output logic [22:0] peak_r,
    output logic        clip_l,
    output logic        clip_r
);

    localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_DIV - 1);

    // Signed 24b sample times unsigned Q1.7 gain, as a 33b signed product.
    function automatic logic signed [32:0] mul_gain(input logic [23:0] s, input logic [7:0] g);
        return $signed({{9{s[23]}}, s}) * $signed({25'd0, g});
    endfunction

    // Drop the 7 fraction bits (floor) and clamp to 24b; MSB of the result flags saturation.
    function automatic logic [24:0] shift_sat(input logic signed [32:0] prod);
        logic signed [32:0] sh;
        sh = prod >>> 7;
        if (sh[32:23] == {10{sh[32]}}) begin
            return {1'b0, sh[23:0]};
        end else if (sh[32]) begin
            return {1'b1, 24'h800000};
        end else begin
            return {1'b1, 24'h7FFFFF};
        end
    endfunction

    // Magnitude of a 24b sample clipped to 23b; the most negative value maps to full scale.
    function automatic logic [22:0] mag23(input logic [23:0] x);
        if (x == 24'h800000) begin
            return 23'h7FFFFF;
        end else if (x[23]) begin
            return (~x[22:0]) + 23'd1;
        end else begin
            return x[22:0];
        end
    endfunction

    logic [RC_W-1:0]    rc_q, rc_d;
    logic [7:0]         cur_gain_q, cur_gain_d;
    logic [7:0]         tgt_s;
    logic [23:0]        in_l_q, in_l_d, in_r_q, in_r_d;
    logic               v0_q, v0_d, v1_q, v1_d;
    logic signed [32:0] prod_l_q, prod_l_d, prod_r_q, prod_r_d;
    logic [23:0]        out_l_q, out_l_d, out_r_q, out_r_d;
    logic               sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic               out_valid_q, out_valid_d;
    logic [24:0]        res_l_s, res_r_s;
    logic [22:0]        mag_l_s, mag_r_s;
    logic [22:0]        peak_l_q, peak_l_d, peak_r_q, peak_r_d;
    logic               clip_l_q, clip_l_d, clip_r_q, clip_r_d;

    // Ramp counter and gain step; the counter keeps running even once the gain has settled.
    always_comb begin
        tgt_s      = mute ? 8'd0 : gain_target;
        rc_d       = rc_q;
        cur_gain_d = cur_gain_q;
        if (strobe) begin
            if (rc_q == RC_LAST) begin
                rc_d = {RC_W{1'b0}};
                if (cur_gain_q < tgt_s) begin
                    cur_gain_d = cur_gain_q + 8'd1;
                end else if (cur_gain_q > tgt_s) begin
                    cur_gain_d = cur_gain_q - 8'd1;
                end else begin
                    cur_gain_d = cur_gain_q;
                end
            end else begin
                rc_d = rc_q + RC_W'(1);
            end
        end else begin
            rc_d = rc_q;
        end
    end

    // Capture stage and multiply stage; the multiply sees the gain already updated by this strobe.
    always_comb begin
        in_l_d   = strobe ? in_l : in_l_q;
        in_r_d   = strobe ? in_r : in_r_q;
        v0_d     = strobe;
        prod_l_d = mul_gain(in_l_q, cur_gain_q);
        prod_r_d = mul_gain(in_r_q, cur_gain_q);
        v1_d     = v0_q;
    end

    // Shift/saturate stage; outputs hold their last value between frames.
    always_comb begin
        res_l_s     = shift_sat(prod_l_q);
        res_r_s     = shift_sat(prod_r_q);
        out_valid_d = v1_q;
        if (v1_q) begin
            out_l_d = res_l_s[23:0];
            out_r_d = res_r_s[23:0];
            sat_l_d = res_l_s[24];
            sat_r_d = res_r_s[24];
        end else begin
            out_l_d = out_l_q;
            out_r_d = out_r_q;
            sat_l_d = sat_l_q;
            sat_r_d = sat_r_q;
        end
    end

    // Peak/clip tracking; a clear coinciding with a new sample restarts from that sample.
    always_comb begin
        mag_l_s = mag23(out_l_q);
        mag_r_s = mag23(out_r_q);
        if (out_valid_q && peak_clr) begin
            peak_l_d = mag_l_s;
            peak_r_d = mag_r_s;
            clip_l_d = sat_l_q;
            clip_r_d = sat_r_q;
        end else if (peak_clr) begin
            peak_l_d = 23'd0;
            peak_r_d = 23'd0;
            clip_l_d = 1'b0;
            clip_r_d = 1'b0;
        end else if (out_valid_q) begin
            peak_l_d = (mag_l_s > peak_l_q) ? mag_l_s : peak_l_q;
            peak_r_d = (mag_r_s > peak_r_q) ? mag_r_s : peak_r_q;
            clip_l_d = clip_l_q | sat_l_q;
            clip_r_d = clip_r_q | sat_r_q;
        end else begin
            peak_l_d = peak_l_q;
            peak_r_d = peak_r_q;
            clip_l_d = clip_l_q;
            clip_r_d = clip_r_q;
        end
    end

    // State registers; reset drops in-flight samples and restarts the gain fade-in from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q        <= {RC_W{1'b0}};
            cur_gain_q  <= 8'd0;
            in_l_q      <= 24'd0;
            in_r_q      <= 24'd0;
            v0_q        <= 1'b0;
            prod_l_q    <= 33'sd0;
            prod_r_q    <= 33'sd0;
            v1_q        <= 1'b0;
            out_l_q     <= 24'd0;
            out_r_q     <= 24'd0;
            sat_l_q     <= 1'b0;
            sat_r_q     <= 1'b0;
            out_valid_q <= 1'b0;
            peak_l_q    <= 23'd0;
            peak_r_q    <= 23'd0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
        end else begin
            rc_q        <= rc_d;
            cur_gain_q  <= cur_gain_d;
            in_l_q      <= in_l_d;
            in_r_q      <= in_r_d;
            v0_q        <= v0_d;
            prod_l_q    <= prod_l_d;
            prod_r_q    <= prod_r_d;
            v1_q        <= v1_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            sat_l_q     <= sat_l_d;
            sat_r_q     <= sat_r_d;
            out_valid_q <= out_valid_d;
            peak_l_q    <= peak_l_d;
            peak_r_q    <= peak_r_d;
            clip_l_q    <= clip_l_d;
            clip_r_q    <= clip_r_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign cur_gain  = cur_gain_q;
    assign peak_l    = peak_l_q;
    assign peak_r    = peak_r_q;
    assign clip_l    = clip_l_q;
    assign clip_r    = clip_r_q;

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Bench for audio_gain_ramp: two instances (RAMP_DIV=1 and 4) share stimulus and are
// compared against an arithmetic reference model of the gain ramp, datapath and peak logic.
module tb_audio_gain_ramp;

    logic        clk = 1'b0;
    logic        rst, strobe, mute, peak_clr;
    logic [23:0] in_l, in_r;
    logic [7:0]  gain_target;

    logic [23:0] o1_out_l, o1_out_r, o4_out_l, o4_out_r;
    logic        o1_valid, o4_valid;
    logic [7:0]  o1_gain, o4_gain;
    logic [22:0] o1_peak_l, o1_peak_r, o4_peak_l, o4_peak_r;
    logic        o1_clip_l, o1_clip_r, o4_clip_l, o4_clip_r;

    always #5 clk = ~clk;

    audio_gain_ramp #(.RAMP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .strobe(strobe), .in_l(in_l), .in_r(in_r),
        .gain_target(gain_target), .mute(mute), .peak_clr(peak_clr),
        .out_l(o1_out_l), .out_r(o1_out_r), .out_valid(o1_valid), .cur_gain(o1_gain),
        .peak_l(o1_peak_l), .peak_r(o1_peak_r), .clip_l(o1_clip_l), .clip_r(o1_clip_r));

    audio_gain_ramp #(.RAMP_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .strobe(strobe), .in_l(in_l), .in_r(in_r),
        .gain_target(gain_target), .mute(mute), .peak_clr(peak_clr),
        .out_l(o4_out_l), .out_r(o4_out_r), .out_valid(o4_valid), .cur_gain(o4_gain),
        .peak_l(o4_peak_l), .peak_r(o4_peak_r), .clip_l(o4_clip_l), .clip_r(o4_clip_r));

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int g1, rc1, g4, rc4;
    int pk_l, pk_r;
    bit cl_l, cl_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx24(input logic [23:0] x);
        int v;
        v = int'({8'd0, x});
        if (x[23]) v = v - 16777216;
        return v;
    endfunction

    function automatic int toward(input int g, input int t);
        if (g < t) return g + 1;
        if (g > t) return g - 1;
        return g;
    endfunction

    function automatic int mag(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return (m > 8388607) ? 8388607 : m;
    endfunction

    task automatic expect_ch(input logic [23:0] x, input int g, output logic [23:0] e, output bit s);
        longint p, q;
        p = longint'(sx24(x)) * longint'(g);
        q = p >>> 7;
        s = 1'b0;
        if (q > 64'sd8388607) begin q = 64'sd8388607; s = 1'b1; end
        if (q < -64'sd8388608) begin q = -64'sd8388608; s = 1'b1; end
        e = q[23:0];
    endtask

    task automatic model_strobe();
        int tgt;
        tgt = mute ? 0 : int'(gain_target);
        g1 = toward(g1, tgt);
        if (rc4 == 3) begin rc4 = 0; g4 = toward(g4, tgt); end
        else rc4 = rc4 + 1;
    endtask

    task automatic model_reset();
        g1 = 0; rc1 = 0; g4 = 0; rc4 = 0;
        pk_l = 0; pk_r = 0; cl_l = 1'b0; cl_r = 1'b0;
    endtask

    task automatic peak_model(input logic [23:0] el, input logic [23:0] er,
                              input bit sl, input bit sr, input bit clr);
        int ml, mr;
        ml = mag(sx24(el));
        mr = mag(sx24(er));
        if (clr) begin
            pk_l = ml; pk_r = mr; cl_l = sl; cl_r = sr;
        end else begin
            if (ml > pk_l) pk_l = ml;
            if (mr > pk_r) pk_r = mr;
            cl_l = cl_l | sl;
            cl_r = cl_r | sr;
        end
    endtask

    task automatic chk_status();
        chk("peak_l", 32'(o1_peak_l), 32'(pk_l));
        chk("peak_r", 32'(o1_peak_r), 32'(pk_r));
        chk("clip_l", 32'(o1_clip_l), 32'(cl_l));
        chk("clip_r", 32'(o1_clip_r), 32'(cl_r));
    endtask

    // One isolated frame; entered and left just after a falling edge.
    task automatic do_strobe(input logic [23:0] l, input logic [23:0] r, input bit clr);
        logic [23:0] el, er;
        bit sl, sr;
        in_l = l; in_r = r; strobe = 1'b1;
        @(posedge clk);
        model_strobe();
        expect_ch(l, g1, el, sl);
        expect_ch(r, g1, er, sr);
        @(negedge clk);
        strobe = 1'b0; in_l = 24'($urandom); in_r = 24'($urandom);
        chk("valid_e1", 32'(o1_valid), 32'd0);
        @(negedge clk);
        chk("valid_e2", 32'(o1_valid), 32'd0);
        @(negedge clk);
        chk("valid_e2e3", 32'(o1_valid), 32'd1);
        chk("out_l", 32'(o1_out_l), 32'(el));
        chk("out_r", 32'(o1_out_r), 32'(er));
        chk("gain1", 32'(o1_gain), 32'(g1));
        chk("gain4", 32'(o4_gain), 32'(g4));
        peak_clr = clr;
        @(negedge clk);
        peak_clr = 1'b0;
        peak_model(el, er, sl, sr, clr);
        chk("valid_after", 32'(o1_valid), 32'd0);
        chk_status();
    endtask

    task automatic burst3();
        logic [23:0] el [3];
        logic [23:0] er [3];
        bit sl [3];
        bit sr [3];
        for (int i = 0; i < 3; i++) begin
            in_l = 24'($urandom); in_r = 24'($urandom); strobe = 1'b1;
            @(posedge clk);
            model_strobe();
            expect_ch(in_l, g1, el[i], sl[i]);
            expect_ch(in_r, g1, er[i], sr[i]);
            @(negedge clk);
        end
        strobe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("burst_valid", 32'(o1_valid), 32'd1);
            chk("burst_out_l", 32'(o1_out_l), 32'(el[i]));
            chk("burst_out_r", 32'(o1_out_r), 32'(er[i]));
            peak_model(el[i], er[i], sl[i], sr[i], 1'b0);
            @(negedge clk);
        end
        chk("burst_valid_end", 32'(o1_valid), 32'd0);
        chk("burst_gain1", 32'(o1_gain), 32'(g1));
        chk_status();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_alone();
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        pk_l = 0; pk_r = 0; cl_l = 1'b0; cl_r = 1'b0;
        chk_status();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1; strobe = 1'b0; in_l = 24'd0; in_r = 24'd0;
        gain_target = 8'd128; mute = 1'b0; peak_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_l", 32'(o1_out_l), 32'd0);
        chk("rst_out_r", 32'(o1_out_r), 32'd0);
        chk("rst_valid", 32'(o1_valid), 32'd0);
        chk("rst_gain", 32'(o1_gain), 32'd0);
        chk_status();
        rst = 1'b0;
        @(negedge clk);

        // fade-in to unity with constant left input
        for (int k = 1; k <= 130; k++) begin
            do_strobe(24'h100000, 24'($urandom), 1'b0);
            if (k == 128) chk("gain_at_128", 32'(o1_gain), 32'd128);
            if (k >= 128) chk("unity_out", 32'(o1_out_l), 32'h100000);
        end

        // ramp rate with RAMP_DIV=4
        apply_reset();
        gain_target = 8'd8;
        for (int k = 1; k <= 40; k++) begin
            do_strobe(24'($urandom), 24'($urandom), 1'b0);
            chk("div4_gain", 32'(o4_gain), 32'((k / 4 < 8) ? k / 4 : 8));
        end

        // saturation at full gain
        gain_target = 8'd255;
        guard = 0;
        while (g1 != 255 && guard < 300) begin
            do_strobe(24'($urandom), 24'($urandom), 1'b0);
            guard++;
        end
        chk("reach_255", 32'(o1_gain), 32'd255);
        clear_alone();
        do_strobe(24'h7FFFFF, 24'h800000, 1'b0);
        chk("sat_pos", 32'(o1_out_l), 32'h7FFFFF);
        chk("sat_neg", 32'(o1_out_r), 32'h800000);
        chk("sat_peak_r", 32'(o1_peak_r), 32'h7FFFFF);
        chk("sat_clip_l", 32'(o1_clip_l), 32'd1);
        chk("sat_clip_r", 32'(o1_clip_r), 32'd1);
        clear_alone();
        do_strobe(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        chk("neg_one", 32'(o1_out_l), 32'hFFFFFE);
        chk("neg_one_noclip", 32'(o1_clip_l), 32'd0);
        burst3();

        // mute ramp-down and mid-ramp un-mute
        gain_target = 8'd128;
        guard = 0;
        while (g1 != 128 && guard < 200) begin
            do_strobe(24'($urandom), 24'($urandom), 1'b0);
            guard++;
        end
        mute = 1'b1;
        guard = 0;
        while (g1 != 60 && guard < 200) begin
            do_strobe(24'($urandom), 24'($urandom), 1'b0);
            guard++;
        end
        chk("mute_at_60", 32'(o1_gain), 32'd60);
        mute = 1'b0;
        do_strobe(24'($urandom), 24'($urandom), 1'b0);
        chk("unmute_61", 32'(o1_gain), 32'd61);
        mute = 1'b1;
        guard = 0;
        while (g1 != 0 && guard < 200) begin
            do_strobe(24'($urandom), 24'($urandom), 1'b0);
            guard++;
        end
        do_strobe(24'($urandom), 24'($urandom), 1'b0);
        chk("mute_out_l", 32'(o1_out_l), 32'd0);
        chk("mute_out_r", 32'(o1_out_r), 32'd0);

        // peak tracking and clear
        mute = 1'b0;
        guard = 0;
        while (g1 != 128 && guard < 200) begin
            do_strobe(24'($urandom), 24'($urandom), 1'b0);
            guard++;
        end
        clear_alone();
        do_strobe(24'h000100, 24'h000100, 1'b0);
        do_strobe(24'h000800, 24'h000800, 1'b0);
        do_strobe(24'h000200, 24'h000200, 1'b0);
        chk("peak_max", 32'(o1_peak_l), 32'h000800);
        clear_alone();
        chk("peak_cleared", 32'(o1_peak_l), 32'd0);
        do_strobe(24'h000800, 24'h000800, 1'b0);
        do_strobe(24'h000300, 24'h000300, 1'b1);
        chk("clr_and_load", 32'(o1_peak_l), 32'h000300);
        burst3();

        // reset while a sample is in flight
        in_l = 24'h123456; in_r = 24'h654321; strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        strobe = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_valid", 32'(o1_valid), 32'd0);
        chk("midrst_out_l", 32'(o1_out_l), 32'd0);
        chk("midrst_out_r", 32'(o1_out_r), 32'd0);
        chk("midrst_gain", 32'(o1_gain), 32'd0);
        chk_status();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(o1_valid), 32'd0);
        end
        do_strobe(24'h400000, 24'($urandom), 1'b0);
        chk("post_rst_gain", 32'(o1_gain), 32'd1);
        chk("post_rst_out", 32'(o1_out_l), 32'h008000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
